vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator; successor to the fixed-timing VGA block.
- Adds a pixel-clock-enable divider, configurable sync polarity, and run/stop control that stops only at a frame boundary.
- Adds a fetch-ahead coordinate port with a LATENCY-tick delayed draw/sync path, plus frame/line pulses and a frame counter.
- Sits between the system clock domain and the VGA pins; feeds the game-of-life frame-buffer reader.

Parameters:
- H_ACTIVE, VGA_H_ACTIVE, visible pixels per line
- H_FRONT, VGA_H_FRONT, horizontal front porch (pixels)
- H_SYNC, VGA_H_SYNC, hsync width (pixels)
- H_BACK, VGA_H_BACK, horizontal back porch (pixels)
- V_ACTIVE, VGA_V_ACTIVE, visible lines
- V_FRONT, VGA_V_FRONT, vertical front porch (lines)
- V_SYNC, VGA_V_SYNC, vsync width (lines)
- V_BACK, VGA_V_BACK, vertical back porch (lines)
- PIX_DIV, 1, clk cycles per pixel tick (>=1)
- LATENCY, 0, pixel ticks by which draw/sync lag fetch coordinates (0..8)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- FRAME_CNT_W, 16, frame counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  run request
- o_busy  out  1  state != IDLE
- o_pix_ce  out  1  pixel tick strobe
- o_fetch_valid  out  1  current position is in the active area and state != IDLE
- o_fetch_x  out  $clog2(H_ACTIVE)  current x when fetch_valid, else 0
- o_fetch_y  out  $clog2(V_ACTIVE)  current y when fetch_valid, else 0
- o_draw_active  out  1  delayed active flag
- o_h_sync  out  1  delayed hsync at HSYNC_POL
- o_v_sync  out  1  delayed vsync at VSYNC_POL
- o_line_start  out  1  pulse at x==0
- o_frame_start  out  1  pulse at x==0, y==0
- o_frame_cnt  out  FRAME_CNT_W  completed-frame-start count

Behaviour:
- Totals: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*. Position registers are $clog2(TOTAL) bits wide.
- Reset values:
  - state IDLE; position (0,0); divider 0; pipeline flushed.
  - o_h_sync = !HSYNC_POL, o_v_sync = !VSYNC_POL.
  - All other outputs 0.
- Divider:
  - Counts 0..PIX_DIV-1 only while state != IDLE; cleared in IDLE.
  - o_pix_ce = busy && (div == PIX_DIV-1). PIX_DIV=1 gives o_pix_ce = busy.
- Position: advances on o_pix_ce only. x wraps H_TOTAL-1 -> 0 and increments y; y wraps V_TOTAL-1 -> 0.
- FSM:
  - IDLE -> RUN when i_en=1; position is (0,0) on the first RUN cycle.
  - RUN -> STOPPING when i_en=0.
  - STOPPING -> RUN when i_en=1 again; no disruption to timing.
  - STOPPING -> IDLE on the pix_ce at (H_TOTAL-1, V_TOTAL-1); position becomes (0,0).
- Fetch outputs are combinational from position and state: o_fetch_valid = busy && x<H_ACTIVE && y<V_ACTIVE.
- Sync decode:
  - hsync is asserted for H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync uses the same form on y.
  - Both outputs are inverted per POL.
- Delayed path:
  - LATENCY=0: draw/sync are decoded combinationally from the current position.
  - LATENCY=N: draw/sync equal the decode from N pix_ce ticks earlier, through an N-stage register pipe that shifts only on pix_ce.
  - Pipe stages reset to the inactive value and are forced inactive while IDLE.
- Pulses:
  - o_line_start = o_pix_ce && x==0.
  - o_frame_start = o_pix_ce && x==0 && y==0.
  - Each is high for one clk cycle.
- o_frame_cnt increments on o_frame_start and wraps modulo 2^FRAME_CNT_W. It is not cleared by stop/start, only by rst_n.
- Reset mid-frame: all state is returned to reset values immediately (asynchronous); the next frame restarts from (0,0).
- i_en toggling within one pix period is sampled every clk; only the level at the final tick of the frame decides the stop.

Decomposition:
- Package defs_vga holds:
  - the default timing constants;
  - enum vga_tg_state_t {IDLE, RUN, STOPPING};
  - a function computing totals.
- Reuse get_next_coords for the position advance.
- One new sub-module, vga_sync_delay: parametrised depth/width shift pipe with clock enable and a reset value.

Test Plan:
- Small timing H=8/2/3/1, V=4/1/2/1, PIX_DIV=1, LATENCY=0, i_en=1 from reset:
  - o_h_sync low exactly at x=10..12;
  - o_v_sync low at y=5..6;
  - 32 fetch_valid cycles per frame;
  - frame_start every 112 clks.
- Same timing with PIX_DIV=3: pix_ce every 3rd clk; frame period 336 clks; x holds for 3 clks.
- LATENCY=2: o_draw_active rises exactly 2 pix_ce after the first fetch_valid; hsync low at x=12..14 relative to the fetch x.
- i_en dropped at (3,2):
  - frame completes;
  - o_busy falls after the pix_ce at (13,7);
  - outputs idle (syncs high, draw 0);
  - o_frame_cnt frozen.
- i_en dropped then re-raised before frame end: no IDLE entry; frame timing continuous; frame_cnt keeps counting.
- HSYNC_POL=1, VSYNC_POL=1, plus rst_n asserted mid-line:
  - syncs drop to 0 (inactive) asynchronously;
  - after release, x=y=0 and frame_cnt=0.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants, generator state type and coordinate helpers.
// Default timing is the standard 640x480 mode.
package defs_vga;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} vga_tg_state_t;

    function automatic int calc_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // Raster-order successor of (x, y) inside an h_total x v_total frame.
    function automatic void get_next_coords(input int x, input int y,
                                            input int h_total, input int v_total,
                                            output int nx, output int ny);
        nx = x + 1;
        ny = y;
        if (x == h_total - 1) begin
            nx = 0;
            ny = (y == v_total - 1) ? 0 : y + 1;
        end
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Run control plus fetch, draw/sync and frame-status signals of the VGA timing generator.
// The generator drives through master; the frame-buffer reader / pin side uses slave.
interface vga_timing_gen_if #(
    parameter int FX_W        = 10,
    parameter int FY_W        = 9,
    parameter int FRAME_CNT_W = 16
);
    logic                   i_en;
    logic                   o_busy;
    logic                   o_pix_ce;
    logic                   o_fetch_valid;
    logic [FX_W-1:0]        o_fetch_x;
    logic [FY_W-1:0]        o_fetch_y;
    logic                   o_draw_active;
    logic                   o_h_sync;
    logic                   o_v_sync;
    logic                   o_line_start;
    logic                   o_frame_start;
    logic [FRAME_CNT_W-1:0] o_frame_cnt;

    modport master (
        input  i_en,
        output o_busy, o_pix_ce, o_fetch_valid, o_fetch_x, o_fetch_y,
               o_draw_active, o_h_sync, o_v_sync, o_line_start, o_frame_start,
               o_frame_cnt
    );

    modport slave (
        output i_en,
        input  o_busy, o_pix_ce, o_fetch_valid, o_fetch_x, o_fetch_y,
               o_draw_active, o_h_sync, o_v_sync, o_line_start, o_frame_start,
               o_frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Shift pipe of DEPTH stages that advances only on i_ce; i_clr forces every
// stage back to RST_VAL (used to blank the draw/sync path while idle).
module vga_sync_delay #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
        end else if (i_ce) begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock-enable divider, frame-boundary
// run/stop control, fetch-ahead coordinates and a LATENCY-tick delayed draw/sync path.
module vga_timing_gen
    import defs_vga::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FRONT     = VGA_H_FRONT,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BACK      = VGA_H_BACK,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FRONT     = VGA_V_FRONT,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BACK      = VGA_V_BACK,
    parameter int PIX_DIV     = 1,
    parameter int LATENCY     = 0,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int FRAME_CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int FXW     = $clog2(H_ACTIVE);
    localparam int FYW     = $clog2(V_ACTIVE);
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;

    vga_tg_state_t          r_state;
    logic [DIV_W-1:0]       r_div;
    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic w_busy, w_pix_ce, w_last, w_active, w_hs_on, w_vs_on, w_frame_start;
    int   w_nx, w_ny;
    logic [2:0] w_dec, w_dly;

    assign w_busy   = (r_state != IDLE);
    assign w_pix_ce = w_busy && (int'(r_div) == PIX_DIV - 1);
    assign w_last   = w_pix_ce && (int'(r_x) == H_TOTAL - 1) && (int'(r_y) == V_TOTAL - 1);

    always_comb begin
        w_nx = 0;
        w_ny = 0;
        get_next_coords(int'(r_x), int'(r_y), H_TOTAL, V_TOTAL, w_nx, w_ny);
    end

    // The stop decision looks only at i_en on the final tick of the frame, so
    // short drops of i_en earlier in the frame never cut a frame short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_div <= '0;
                    r_x   <= '0;
                    r_y   <= '0;
                    if (bus.i_en) r_state <= RUN;
                end
                default: begin
                    r_div <= w_pix_ce ? '0 : r_div + DIV_W'(1);
                    if (w_pix_ce) begin
                        r_x <= XW'(w_nx);
                        r_y <= YW'(w_ny);
                    end
                    if (w_last && !bus.i_en) r_state <= IDLE;
                    else                     r_state <= bus.i_en ? RUN : STOPPING;
                end
            endcase
        end
    end

    assign w_frame_start = w_pix_ce && (r_x == '0) && (r_y == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_frame_cnt <= '0;
        else if (w_frame_start) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end

    assign w_active = (int'(r_x) < H_ACTIVE) && (int'(r_y) < V_ACTIVE);
    assign w_hs_on  = (int'(r_x) >= HS_BEG) && (int'(r_x) < HS_END);
    assign w_vs_on  = (int'(r_y) >= VS_BEG) && (int'(r_y) < VS_END);
    // Decode kept active-high {draw, hsync, vsync}; polarity applied at the pins.
    assign w_dec    = {w_active, w_hs_on, w_vs_on} & {3{w_busy}};

    generate
        if (LATENCY == 0) begin : g_no_delay
            assign w_dly = w_dec;
        end else begin : g_delay
            logic [2:0] w_dly_q;
            vga_sync_delay #(
                .DEPTH   (LATENCY),
                .WIDTH   (3),
                .RST_VAL (3'b000)
            ) u_sync_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .i_ce  (w_pix_ce),
                .i_clr (!w_busy),
                .i_d   (w_dec),
                .o_q   (w_dly_q)
            );
            assign w_dly = w_dly_q & {3{w_busy}};
        end
    endgenerate

    assign bus.o_busy        = w_busy;
    assign bus.o_pix_ce      = w_pix_ce;
    assign bus.o_fetch_valid = w_active && w_busy;
    assign bus.o_fetch_x     = (w_active && w_busy) ? r_x[FXW-1:0] : '0;
    assign bus.o_fetch_y     = (w_active && w_busy) ? r_y[FYW-1:0] : '0;
    assign bus.o_draw_active = w_dly[2];
    assign bus.o_h_sync      = (HSYNC_POL != 0) ? w_dly[1] : !w_dly[1];
    assign bus.o_v_sync      = (VSYNC_POL != 0) ? w_dly[0] : !w_dly[0];
    assign bus.o_line_start  = w_pix_ce && (r_x == '0);
    assign bus.o_frame_start = w_frame_start;
    assign bus.o_frame_cnt   = r_frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (plain, PIX_DIV=3, LATENCY=2 with
// active-high syncs) on a 14x8 raster, checked against a frame-index model.
module tb_vga_timing_gen;
    localparam int HT = 14;
    localparam int VT = 8;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.FX_W(3), .FY_W(2), .FRAME_CNT_W(16)) if0 (), if1 (), if2 ();
    assign if0.i_en = en;
    assign if1.i_en = en;
    assign if2.i_en = en;

    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .PIX_DIV(1), .LATENCY(0), .HSYNC_POL(0), .VSYNC_POL(0),
                     .FRAME_CNT_W(16))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .PIX_DIV(3), .LATENCY(0), .HSYNC_POL(0), .VSYNC_POL(0),
                     .FRAME_CNT_W(16))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                     .PIX_DIV(1), .LATENCY(2), .HSYNC_POL(1), .VSYNC_POL(1),
                     .FRAME_CNT_W(16))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    function automatic int div_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 2) ? 2 : 0;
    endfunction
    function automatic bit pol_of(input int d);
        return (d == 2);
    endfunction

    function automatic logic [31:0] pack(input logic [15:0] fc, input logic b, input logic ce,
                                         input logic fv, input logic [2:0] fx, input logic [1:0] fy,
                                         input logic dr, input logic hs, input logic vs,
                                         input logic ls, input logic fs);
        return {3'b000, fc, b, ce, fv, fx, fy, dr, hs, vs, ls, fs};
    endfunction

    logic [31:0] obs [3];
    assign obs[0] = pack(if0.o_frame_cnt, if0.o_busy, if0.o_pix_ce, if0.o_fetch_valid, if0.o_fetch_x,
                         if0.o_fetch_y, if0.o_draw_active, if0.o_h_sync, if0.o_v_sync,
                         if0.o_line_start, if0.o_frame_start);
    assign obs[1] = pack(if1.o_frame_cnt, if1.o_busy, if1.o_pix_ce, if1.o_fetch_valid, if1.o_fetch_x,
                         if1.o_fetch_y, if1.o_draw_active, if1.o_h_sync, if1.o_v_sync,
                         if1.o_line_start, if1.o_frame_start);
    assign obs[2] = pack(if2.o_frame_cnt, if2.o_busy, if2.o_pix_ce, if2.o_fetch_valid, if2.o_fetch_x,
                         if2.o_fetch_y, if2.o_draw_active, if2.o_h_sync, if2.o_v_sync,
                         if2.o_line_start, if2.o_frame_start);

    // Model: a running instance is m_c clocks into its run; pixel index is m_c/PIX_DIV.
    bit m_run  [3] = '{0, 0, 0};
    int m_c    [3] = '{0, 0, 0};
    int m_fcnt [3] = '{0, 0, 0};

    function automatic bit m_ce(input int d);
        return (m_c[d] % div_of(d)) == div_of(d) - 1;
    endfunction
    function automatic int m_pos(input int d);
        return (m_c[d] / div_of(d)) % FR;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                m_run[d]  <= 1'b0;
                m_c[d]    <= 0;
                m_fcnt[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (!m_run[d]) begin
                    if (en) begin
                        m_run[d] <= 1'b1;
                        m_c[d]   <= 0;
                    end
                end else begin
                    if (m_ce(d) && m_pos(d) == 0) m_fcnt[d] <= m_fcnt[d] + 1;
                    if (m_ce(d) && m_pos(d) == FR - 1 && !en) m_run[d] <= 1'b0;
                    else                                      m_c[d]   <= m_c[d] + 1;
                end
            end
        end
    end

    function automatic logic [31:0] expect_out(input int d);
        int  n, p, x, y, q, qx, qy;
        bit  ce, fv, dr, hs, vs, pol;
        pol = pol_of(d);
        if (!m_run[d]) return pack(16'(m_fcnt[d]), 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, !pol, !pol, 1'b0, 1'b0);
        n  = m_c[d] / div_of(d);
        p  = n % FR;
        x  = p % HT;
        y  = p / HT;
        ce = m_ce(d);
        fv = (x < 8) && (y < 4);
        dr = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        if (n >= lat_of(d)) begin
            q  = (n - lat_of(d)) % FR;
            qx = q % HT;
            qy = q / HT;
            dr = (qx < 8) && (qy < 4);
            hs = (qx >= 10) && (qx < 13);
            vs = (qy >= 5) && (qy < 7);
        end
        return pack(16'(m_fcnt[d]), 1'b1, ce, fv, fv ? 3'(x) : 3'd0, fv ? 2'(y) : 2'd0, dr,
                    pol ? hs : !hs, pol ? vs : !vs, ce && x == 0, ce && p == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, required 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) chk($sformatf("dut%0d outputs", d), obs[d], expect_out(d));
    end

    int fv_cnt = 0, hs_lo = 0, vs_lo = 0, ce1 = 0, fs0 = 0, first_draw = -1;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset u0 hsync", 32'(if0.o_h_sync), 1);
        chk("reset u0 vsync", 32'(if0.o_v_sync), 1);
        chk("reset u2 hsync", 32'(if2.o_h_sync), 0);
        chk("reset u0 busy", 32'(if0.o_busy), 0);
        chk("reset u0 fetch_valid", 32'(if0.o_fetch_valid), 0);
        en = 1'b1;
        @(negedge clk);
        // first RUN cycle, run clock 0
        chk("u0 first frame_start", 32'(if0.o_frame_start), 1);
        chk("u1 first frame_start", 32'(if1.o_frame_start), 0);
        for (int k = 0; k < FR; k++) begin
            if (if0.o_fetch_valid) fv_cnt++;
            if (!if0.o_h_sync) hs_lo++;
            if (!if0.o_v_sync) vs_lo++;
            if (if1.o_pix_ce) ce1++;
            if (if0.o_frame_start) fs0++;
            if (first_draw < 0 && if2.o_draw_active) first_draw = k;
            if (k == 4)  chk("u1 x hold", 32'(if1.o_fetch_x), 1);
            if (k == 6)  chk("u1 x step", 32'(if1.o_fetch_x), 2);
            if (k == 11) chk("u2 hsync before", 32'(if2.o_h_sync), 0);
            if (k == 12) chk("u2 hsync start", 32'(if2.o_h_sync), 1);
            if (k == 14) chk("u2 hsync last", 32'(if2.o_h_sync), 1);
            if (k == 15) chk("u2 hsync after", 32'(if2.o_h_sync), 0);
            @(negedge clk);
        end
        chk("u0 fetch_valid per frame", 32'(fv_cnt), 32);
        chk("u0 hsync low per frame", 32'(hs_lo), 24);
        chk("u0 vsync low per frame", 32'(vs_lo), 28);
        chk("u1 pix_ce in 112 clks", 32'(ce1), 37);
        chk("u0 frame_start in frame", 32'(fs0), 1);
        chk("u2 draw latency", 32'(first_draw), 2);
        chk("u0 frame_start period", 32'(if0.o_frame_start), 1);
        chk("u0 frame_cnt frame1", 32'(if0.o_frame_cnt), 1);
        repeat (143) @(negedge clk);
        // run clock 255: u0 at (3,2)
        chk("u0 fetch_x at drop", 32'(if0.o_fetch_x), 3);
        chk("u0 fetch_y at drop", 32'(if0.o_fetch_y), 2);
        en = 1'b0;
        repeat (80) @(negedge clk);
        chk("u0 final tick busy", 32'(if0.o_busy), 1);
        chk("u0 final tick pix_ce", 32'(if0.o_pix_ce), 1);
        chk("u1 final tick pix_ce", 32'(if1.o_pix_ce), 1);
        @(negedge clk);
        chk("u0 busy after stop", 32'(if0.o_busy), 0);
        chk("u1 busy after stop", 32'(if1.o_busy), 0);
        chk("u0 hsync idle", 32'(if0.o_h_sync), 1);
        chk("u2 draw idle", 32'(if2.o_draw_active), 0);
        chk("u0 frame_cnt at stop", 32'(if0.o_frame_cnt), 3);
        chk("u1 frame_cnt at stop", 32'(if1.o_frame_cnt), 1);
        repeat (20) @(negedge clk);
        chk("u0 frame_cnt frozen", 32'(if0.o_frame_cnt), 3);
        en = 1'b1;
        @(negedge clk);
        chk("u0 restart fetch_valid", 32'(if0.o_fetch_valid), 1);
        chk("u0 restart fetch_x", 32'(if0.o_fetch_x), 0);
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        repeat (130) @(negedge clk);
        // run clock 200 of second run
        chk("u0 busy through glitch", 32'(if0.o_busy), 1);
        chk("u0 frame_cnt continues", 32'(if0.o_frame_cnt), 5);
        chk("u1 frame_cnt continues", 32'(if1.o_frame_cnt), 2);
        chk("u2 vsync active pre-reset", 32'(if2.o_v_sync), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst u2 hsync", 32'(if2.o_h_sync), 0);
        chk("async rst u2 vsync", 32'(if2.o_v_sync), 0);
        chk("async rst u0 vsync", 32'(if0.o_v_sync), 1);
        chk("async rst u0 busy", 32'(if0.o_busy), 0);
        chk("async rst u0 frame_cnt", 32'(if0.o_frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst u0 fetch_valid", 32'(if0.o_fetch_valid), 1);
        chk("post-rst u0 fetch_x", 32'(if0.o_fetch_x), 0);
        chk("post-rst u0 fetch_y", 32'(if0.o_fetch_y), 0);
        chk("post-rst u0 frame_cnt", 32'(if0.o_frame_cnt), 0);
        repeat (30) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
